rob_param: RTL and testbench

Parametrised in-order-commit reorder buffer for the out-of-order core, sitting between decode/rename (dispatch), the ALU and load/store units (writeback), the register file (commit) and the fetch unit (redirect). Depth, data width and writeback port count are generic. Mispredicted control flow flushes all younger entries in one cycle. Operands can be read by tag for rename bypass.

---
 rtl/rob_pkg.sv | 24 ++
 rtl/rob_ptr.sv | 29 ++
 rtl/rob_param.sv | 155 +++++++++++++++
 tb/tb_rob_param.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and default sizes for the reorder buffer.
// Entry control fields live here; data widths stay per-instance.
package rob_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_XLEN  = 32;
  localparam int ROB_NWB   = 2;

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_EXEC,
    ST_LS_WAIT,
    ST_LS_GO,
    ST_DONE
  } rob_state_e;

  typedef struct packed {
    rob_state_e state;
    logic [4:0] rd;
    logic       is_ls;
    logic       redirect;
  } rob_ctl_t;

endpackage

// File: rtl/rob_ptr.sv
// Modulo-DEPTH pointer with increment and load.
// Load has priority over increment.
module rob_ptr #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             load,
  input  logic [TAG_W-1:0] load_val,
  output logic [TAG_W-1:0] ptr
);

  logic [TAG_W-1:0] ptr_inc;

  assign ptr_inc = (ptr == TAG_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;

  // pointer register: load wins, else step with wrap
  always_ff @(posedge clk) begin
    if (!rst)
      ptr <= '0;
    else if (load)
      ptr <= load_val;
    else if (inc)
      ptr <= ptr_inc;
  end

endmodule

// File: rtl/rob_param.sv
// In-order-commit reorder buffer with flush on retired redirect.
// One retire per cycle; queries read stored state only.
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int XLEN  = ROB_XLEN,
  parameter int NWB   = ROB_NWB,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                disp_valid,
  output logic                disp_ready,
  input  logic [4:0]          disp_rd,
  input  logic                disp_is_ls,
  output logic [TAG_W-1:0]    disp_tag,
  input  logic [NWB-1:0]      wb_valid,
  input  logic [NWB*TAG_W-1:0] wb_tag,
  input  logic [NWB*XLEN-1:0] wb_value,
  input  logic [NWB-1:0]      wb_redirect,
  input  logic [NWB*XLEN-1:0] wb_target,
  input  logic                lsr_valid,
  input  logic [TAG_W-1:0]    lsr_tag,
  input  logic [TAG_W-1:0]    q1_tag,
  input  logic [TAG_W-1:0]    q2_tag,
  output logic                q1_ready,
  output logic                q2_ready,
  output logic [XLEN-1:0]     q1_value,
  output logic [XLEN-1:0]     q2_value,
  output logic                commit_valid,
  output logic [4:0]          commit_rd,
  output logic [XLEN-1:0]     commit_value,
  output logic [TAG_W-1:0]    commit_tag,
  output logic                ls_commit,
  output logic [TAG_W-1:0]    ls_tag,
  output logic                redirect_valid,
  output logic [XLEN-1:0]     redirect_pc,
  output logic [TAG_W:0]      count
);

  rob_ctl_t          ctl [DEPTH];
  logic [XLEN-1:0]   val [DEPTH];
  logic [XLEN-1:0]   tgt [DEPTH];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W-1:0]  head_nxt;
  logic [TAG_W-1:0]  wbt [NWB];
  logic              retire;
  logic              flush;
  logic              disp_fire;

  assign head_nxt  = (head == TAG_W'(DEPTH - 1)) ? '0 : head + 1'b1;
  assign retire    = (ctl[head].state == ST_DONE);
  assign flush     = retire && ctl[head].redirect;
  assign disp_ready = (count < (TAG_W+1)'(DEPTH)) && !flush;
  assign disp_fire = disp_valid && disp_ready;
  assign disp_tag  = tail;

  assign ls_commit = (ctl[head].state == ST_LS_WAIT);
  assign ls_tag    = ls_commit ? head : '0;

  assign q1_ready  = (ctl[q1_tag].state == ST_DONE);
  assign q2_ready  = (ctl[q2_tag].state == ST_DONE);
  assign q1_value  = val[q1_tag];
  assign q2_value  = val[q2_tag];

  // unpack per-port writeback tags
  always_comb begin
    for (int i = 0; i < NWB; i++)
      wbt[i] = wb_tag[i*TAG_W +: TAG_W];
  end

  rob_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_head (
    .clk      (clk),
    .rst      (rst),
    .inc      (retire),
    .load     (1'b0),
    .load_val ('0),
    .ptr      (head)
  );

  rob_ptr #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_tail (
    .clk      (clk),
    .rst      (rst),
    .inc      (disp_fire),
    .load     (flush),
    .load_val (head_nxt),
    .ptr      (tail)
  );

  // entry state: dispatch, store resolve, writeback, retire, flush
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctl[i] <= '0;
        val[i] <= '0;
        tgt[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++)
        ctl[i].state <= ST_EMPTY;
    end else begin
      if (disp_fire)
        ctl[tail] <= '{state: ST_EXEC, rd: disp_rd,
                       is_ls: disp_is_ls, redirect: 1'b0};
      if (lsr_valid && ctl[lsr_tag].state == ST_EXEC
          && ctl[lsr_tag].is_ls)
        ctl[lsr_tag].state <= ST_LS_WAIT;
      if (ls_commit)
        ctl[head].state <= ST_LS_GO;
      for (int i = 0; i < NWB; i++) begin
        if (wb_valid[i] && (ctl[wbt[i]].state == ST_EXEC
            || ctl[wbt[i]].state == ST_LS_GO)) begin
          ctl[wbt[i]].state    <= ST_DONE;
          ctl[wbt[i]].redirect <= wb_redirect[i];
          val[wbt[i]] <= wb_value[i*XLEN +: XLEN];
          tgt[wbt[i]] <= wb_target[i*XLEN +: XLEN];
        end
      end
      if (retire)
        ctl[head].state <= ST_EMPTY;
    end
  end

  // registered commit/redirect outputs and occupancy
  always_ff @(posedge clk) begin
    if (!rst) begin
      count          <= '0;
      commit_valid   <= 1'b0;
      commit_rd      <= '0;
      commit_value   <= '0;
      commit_tag     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      commit_valid   <= retire && (ctl[head].rd != 5'd0);
      redirect_valid <= flush;
      if (retire && ctl[head].rd != 5'd0) begin
        commit_rd    <= ctl[head].rd;
        commit_value <= val[head];
        commit_tag   <= head;
      end
      if (flush)
        redirect_pc <= tgt[head];
      if (flush)
        count <= '0;
      else
        count <= count + (TAG_W+1)'(disp_fire)
                       - (TAG_W+1)'(retire);
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Directed bench for rob_param: ordering, full, flush,
// store handshake and mid-stream reset.
module tb_rob_param;

  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam int NWB   = 2;
  localparam int TAG_W = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 disp_valid;
  logic                 disp_ready;
  logic [4:0]           disp_rd;
  logic                 disp_is_ls;
  logic [TAG_W-1:0]     disp_tag;
  logic [NWB-1:0]       wb_valid;
  logic [NWB*TAG_W-1:0] wb_tag;
  logic [NWB*XLEN-1:0]  wb_value;
  logic [NWB-1:0]       wb_redirect;
  logic [NWB*XLEN-1:0]  wb_target;
  logic                 lsr_valid;
  logic [TAG_W-1:0]     lsr_tag;
  logic [TAG_W-1:0]     q1_tag;
  logic [TAG_W-1:0]     q2_tag;
  logic                 q1_ready;
  logic                 q2_ready;
  logic [XLEN-1:0]      q1_value;
  logic [XLEN-1:0]      q2_value;
  logic                 commit_valid;
  logic [4:0]           commit_rd;
  logic [XLEN-1:0]      commit_value;
  logic [TAG_W-1:0]     commit_tag;
  logic                 ls_commit;
  logic [TAG_W-1:0]     ls_tag;
  logic                 redirect_valid;
  logic [XLEN-1:0]      redirect_pc;
  logic [TAG_W:0]       count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rob_param #(
    .DEPTH(DEPTH), .XLEN(XLEN), .NWB(NWB), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_rd(disp_rd), .disp_is_ls(disp_is_ls),
    .disp_tag(disp_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
    .wb_redirect(wb_redirect), .wb_target(wb_target),
    .lsr_valid(lsr_valid), .lsr_tag(lsr_tag),
    .q1_tag(q1_tag), .q2_tag(q2_tag),
    .q1_ready(q1_ready), .q2_ready(q2_ready),
    .q1_value(q1_value), .q2_value(q2_value),
    .commit_valid(commit_valid), .commit_rd(commit_rd),
    .commit_value(commit_value), .commit_tag(commit_tag),
    .ls_commit(ls_commit), .ls_tag(ls_tag),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_clear();
    wb_valid    = '0;
    wb_tag      = '0;
    wb_value    = '0;
    wb_redirect = '0;
    wb_target   = '0;
  endtask

  task automatic wb_set(input int p, input logic [TAG_W-1:0] t,
                        input logic [XLEN-1:0] v, input logic r,
                        input logic [XLEN-1:0] pc);
    wb_valid[p] = 1'b1;
    wb_tag[p*TAG_W +: TAG_W] = t;
    wb_value[p*XLEN +: XLEN] = v;
    wb_redirect[p] = r;
    wb_target[p*XLEN +: XLEN] = pc;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    disp_valid = 1'b0;
    disp_rd = '0;
    disp_is_ls = 1'b0;
    lsr_valid = 1'b0;
    lsr_tag = '0;
    q1_tag = '0;
    q2_tag = '0;
    wb_clear();
    do_reset();

    chk("rst_count", count, 0);
    chk("rst_ready", disp_ready, 1);
    chk("rst_tag", disp_tag, 0);
    chk("rst_commit", commit_valid, 0);
    chk("rst_ls", ls_commit, 0);
    chk("rst_redir", redirect_valid, 0);
    chk("rst_q1r", q1_ready, 0);
    chk("rst_q1v", q1_value, 0);

    // out-of-order writeback, in-order commit
    disp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      disp_rd = 5'(i + 1);
      chk("ord_disp_tag", disp_tag, i);
      tick();
    end
    disp_valid = 1'b0;
    chk("ord_count3", count, 3);
    wb_set(1, 3'd2, 32'h20, 1'b0, 32'h0);
    wb_set(0, 3'd0, 32'h00, 1'b0, 32'h0);
    tick();
    wb_clear();
    q1_tag = 3'd2;
    q2_tag = 3'd1;
    #1;
    chk("ord_q1_ready", q1_ready, 1);
    chk("ord_q1_value", q1_value, 32'h20);
    chk("ord_q2_ready", q2_ready, 0);
    chk("ord_no_commit_yet", commit_valid, 0);
    wb_set(0, 3'd1, 32'h10, 1'b0, 32'h0);
    tick();
    wb_clear();
    chk("ord_c0_valid", commit_valid, 1);
    chk("ord_c0_tag", commit_tag, 0);
    chk("ord_c0_rd", commit_rd, 1);
    chk("ord_c0_val", commit_value, 32'h00);
    tick();
    chk("ord_c1_valid", commit_valid, 1);
    chk("ord_c1_tag", commit_tag, 1);
    chk("ord_c1_rd", commit_rd, 2);
    chk("ord_c1_val", commit_value, 32'h10);
    tick();
    chk("ord_c2_valid", commit_valid, 1);
    chk("ord_c2_tag", commit_tag, 2);
    chk("ord_c2_rd", commit_rd, 3);
    chk("ord_c2_val", commit_value, 32'h20);
    tick();
    chk("ord_idle", commit_valid, 0);
    chk("ord_count0", count, 0);

    // fill to DEPTH, then retire one and wrap
    do_reset();
    disp_valid = 1'b1;
    disp_rd = 5'd5;
    for (int i = 0; i < DEPTH; i++) tick();
    chk("full_count", count, 8);
    chk("full_ready", disp_ready, 0);
    tick();
    chk("full_hold", count, 8);
    wb_set(0, 3'd0, 32'h33, 1'b0, 32'h0);
    tick();
    wb_clear();
    chk("full_done_ready", disp_ready, 0);
    tick();
    chk("full_ret_valid", commit_valid, 1);
    chk("full_ret_tag", commit_tag, 0);
    chk("full_ret_count", count, 7);
    chk("full_ready_back", disp_ready, 1);
    chk("full_wrap_tag", disp_tag, 0);
    tick();
    disp_valid = 1'b0;
    chk("full_refill", count, 8);

    // redirect flush
    do_reset();
    disp_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      disp_rd = 5'(i + 1);
      tick();
    end
    disp_valid = 1'b0;
    wb_set(0, 3'd1, 32'h11, 1'b1, 32'h100);
    wb_set(1, 3'd0, 32'h0a, 1'b0, 32'h0);
    tick();
    wb_clear();
    wb_set(0, 3'd2, 32'h22, 1'b0, 32'h0);
    wb_set(1, 3'd3, 32'h33, 1'b0, 32'h0);
    tick();
    wb_clear();
    chk("fl_c0_valid", commit_valid, 1);
    chk("fl_c0_tag", commit_tag, 0);
    chk("fl_block_ready", disp_ready, 0);
    tick();
    chk("fl_c1_valid", commit_valid, 1);
    chk("fl_c1_tag", commit_tag, 1);
    chk("fl_c1_val", commit_value, 32'h11);
    chk("fl_redir_valid", redirect_valid, 1);
    chk("fl_redir_pc", redirect_pc, 32'h100);
    chk("fl_count", count, 0);
    tick();
    chk("fl_no_c2", commit_valid, 0);
    chk("fl_redir_off", redirect_valid, 0);
    chk("fl_tail", disp_tag, 2);
    q1_tag = 3'd2;
    #1;
    chk("fl_q_empty", q1_ready, 0);
    tick();
    chk("fl_no_c3", commit_valid, 0);
    chk("fl_count_hold", count, 0);

    // store at head: single ls_commit, silent retire
    disp_valid = 1'b1;
    disp_rd = 5'd0;
    disp_is_ls = 1'b1;
    tick();
    disp_valid = 1'b0;
    disp_is_ls = 1'b0;
    chk("st_ls_idle", ls_commit, 0);
    lsr_valid = 1'b1;
    lsr_tag = 3'd2;
    tick();
    lsr_valid = 1'b0;
    chk("st_ls_pulse", ls_commit, 1);
    chk("st_ls_tag", ls_tag, 2);
    tick();
    chk("st_ls_once", ls_commit, 0);
    tick();
    chk("st_ls_still0", ls_commit, 0);
    wb_set(1, 3'd2, 32'h55, 1'b0, 32'h0);
    tick();
    wb_clear();
    chk("st_done_nocommit", commit_valid, 0);
    tick();
    chk("st_silent", commit_valid, 0);
    chk("st_count0", count, 0);

    // reset mid-stream with pending writeback
    disp_valid = 1'b1;
    disp_rd = 5'd7;
    tick();
    disp_rd = 5'd8;
    tick();
    chk("mr_count2", count, 2);
    wb_set(0, 3'd3, 32'h77, 1'b0, 32'h0);
    rst = 1'b0;
    tick();
    wb_clear();
    disp_valid = 1'b0;
    chk("mr_count", count, 0);
    chk("mr_commit", commit_valid, 0);
    chk("mr_crd", commit_rd, 0);
    chk("mr_cval", commit_value, 0);
    chk("mr_ctag", commit_tag, 0);
    chk("mr_redir", redirect_valid, 0);
    chk("mr_rpc", redirect_pc, 0);
    chk("mr_ls", ls_commit, 0);
    chk("mr_tag", disp_tag, 0);
    q1_tag = 3'd3;
    #1;
    chk("mr_q1r", q1_ready, 0);
    chk("mr_q1v", q1_value, 0);
    rst = 1'b1;
    disp_valid = 1'b1;
    disp_rd = 5'd9;
    chk("mr_next_tag", disp_tag, 0);
    tick();
    disp_valid = 1'b0;
    chk("mr_next_count", count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
